// File: rtl/buffer_arbiter.sv
// buffer_arbiter
//   Shares one buffer write port between two valid/ready requesters using
//   round-robin arbitration with bounded bursts. It also tracks buffer
//   occupancy and issues read strobes toward a downstream consumer.
//
//   Optional feature macro: BUFFER_ARBITER_STATS_EN
//     When defined, this adds per-port accepted-beat counters (stat_cnt0/1,
//     saturating) and a synchronous clear input (stat_clr).
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   req0_*/req1_*         requester valid/data/ready handshakes
//   buf_wdata, buf_in_en  write data and write strobe to the buffer
//   buf_out_en            read strobe to the buffer
//   dn_ready, dn_valid    downstream ready; read data valid one cycle later
//   grant                 registered one-hot owner (00 when idle)
//   occupancy             number of words held in the buffer
module buffer_arbiter #(
  parameter int N     = 32,
  parameter int DEPTH = 8,
  parameter int BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req0_valid,
  input  logic [N-1:0]               req0_data,
  output logic                       req0_ready,
  input  logic                       req1_valid,
  input  logic [N-1:0]               req1_data,
  output logic                       req1_ready,
  output logic [N-1:0]               buf_wdata,
  output logic                       buf_in_en,
  output logic                       buf_out_en,
  input  logic                       dn_ready,
  output logic                       dn_valid,
  output logic [1:0]                 grant,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef BUFFER_ARBITER_STATS_EN
  ,
  input  logic                       stat_clr,
  output logic [31:0]                stat_cnt0,
  output logic [31:0]                stat_cnt1
`endif
);

  localparam int OW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(BURST + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t          state_reg;
  logic            last_owner_reg;
  logic [BW-1:0]   beat_cnt_reg;
  logic [OW-1:0]   occupancy_reg;
  logic            dn_valid_reg;
  logic [1:0]      grant_reg;

  logic not_full;
  logic accept0;
  logic accept1;
  logic burst_done;

  // Readiness is decided purely by space. A read in the same cycle does not
  // free a slot for a write, so a full buffer never accepts a word.
  assign not_full   = occupancy_reg < OW'(DEPTH);
  assign req0_ready = (state_reg == OWN0) && not_full;
  assign req1_ready = (state_reg == OWN1) && not_full;
  assign accept0    = req0_valid && req0_ready;
  assign accept1    = req1_valid && req1_ready;
  assign buf_in_en  = accept0 || accept1;
  assign buf_wdata  = accept0 ? req0_data : (accept1 ? req1_data : '0);
  assign buf_out_en = dn_ready && (occupancy_reg != '0);
  // The beat being accepted now is the last one the burst allows.
  assign burst_done = buf_in_en && (beat_cnt_reg == BW'(BURST - 1));

  assign dn_valid  = dn_valid_reg;
  assign grant     = grant_reg;
  assign occupancy = occupancy_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= 2'b00;
      last_owner_reg <= 1'b1;
      beat_cnt_reg   <= '0;
      occupancy_reg  <= '0;
      dn_valid_reg   <= 1'b0;
    end else begin
      occupancy_reg <= occupancy_reg + OW'(buf_in_en) - OW'(buf_out_en);
      dn_valid_reg  <= buf_out_en;
      case (state_reg)
        IDLE: begin
          if (req0_valid && req1_valid) begin
            // Tie goes to whichever port did not own the buffer last.
            if (last_owner_reg) begin
              state_reg <= OWN0;
              grant_reg <= 2'b01;
            end else begin
              state_reg <= OWN1;
              grant_reg <= 2'b10;
            end
          end else if (req0_valid) begin
            state_reg <= OWN0;
            grant_reg <= 2'b01;
          end else if (req1_valid) begin
            state_reg <= OWN1;
            grant_reg <= 2'b10;
          end
        end
        OWN0: begin
          if (burst_done || !req0_valid) begin
            last_owner_reg <= 1'b0;
            beat_cnt_reg   <= '0;
            if (req1_valid) begin
              state_reg <= OWN1;
              grant_reg <= 2'b10;
            end else if (!req0_valid) begin
              state_reg <= IDLE;
              grant_reg <= 2'b00;
            end
            // Otherwise stay in OWN0 with a fresh burst.
          end else if (accept0) begin
            beat_cnt_reg <= beat_cnt_reg + 1'b1;
          end
        end
        OWN1: begin
          if (burst_done || !req1_valid) begin
            last_owner_reg <= 1'b1;
            beat_cnt_reg   <= '0;
            if (req0_valid) begin
              state_reg <= OWN0;
              grant_reg <= 2'b01;
            end else if (!req1_valid) begin
              state_reg <= IDLE;
              grant_reg <= 2'b00;
            end
          end else if (accept1) begin
            beat_cnt_reg <= beat_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          grant_reg <= 2'b00;
        end
      endcase
    end
  end

`ifdef BUFFER_ARBITER_STATS_EN
  logic [31:0] stat_cnt0_reg;
  logic [31:0] stat_cnt1_reg;

  // Clear wins over a same-cycle increment; counters hold at all-ones.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_cnt0_reg <= '0;
      stat_cnt1_reg <= '0;
    end else begin
      if (accept0 && (stat_cnt0_reg != '1)) stat_cnt0_reg <= stat_cnt0_reg + 1'b1;
      if (accept1 && (stat_cnt1_reg != '1)) stat_cnt1_reg <= stat_cnt1_reg + 1'b1;
    end
  end

  assign stat_cnt0 = stat_cnt0_reg;
  assign stat_cnt1 = stat_cnt1_reg;
`endif

endmodule

// File: tb/tb_buffer_arbiter.sv
// tb_buffer_arbiter
//   Directed scenarios followed by randomized traffic. Every cycle, all DUT
//   outputs are compared against a behavioural model of the arbitration,
//   occupancy and read rules.
module tb_buffer_arbiter;
  localparam int N     = 32;
  localparam int DEPTH = 8;
  localparam int BURST = 4;
  localparam int OW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          v0, v1, dn;
  logic [N-1:0]  d0, d1;
  logic          r0, r1, in_en, out_en, dvalid;
  logic [N-1:0]  wdata;
  logic [1:0]    grant;
  logic [OW-1:0] occ;
`ifdef BUFFER_ARBITER_STATS_EN
  logic          sclr = 1'b0;
  logic [31:0]   sc0, sc1;
  longint        m_sc0, m_sc1;
`endif

  int checks = 0;
  int errors = 0;

  // Model state: owner 0 = none, 1 = port 0, 2 = port 1; last = port index.
  int m_owner, m_last, m_beats, m_occ;
  bit m_dvalid;

  always #5 clk = ~clk;

  buffer_arbiter #(.N(N), .DEPTH(DEPTH), .BURST(BURST)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_data(d0), .req0_ready(r0),
    .req1_valid(v1), .req1_data(d1), .req1_ready(r1),
    .buf_wdata(wdata), .buf_in_en(in_en), .buf_out_en(out_en),
    .dn_ready(dn), .dn_valid(dvalid), .grant(grant), .occupancy(occ)
`ifdef BUFFER_ARBITER_STATS_EN
    , .stat_clr(sclr), .stat_cnt0(sc0), .stat_cnt1(sc1)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs, compare all outputs with the model, then
  // advance the model across the rising edge.
  task automatic step(input bit r, input bit a0, input bit a1, input bit dr);
    bit e_r0, e_r1, e_acc0, e_acc1, e_out;
    logic [N-1:0] e_wdata;
    int x, other;
    bit vx, vo;
    @(negedge clk);
    rst = r; v0 = a0; v1 = a1; dn = dr;
    d0 = $urandom; d1 = $urandom;
    #1;
    e_r0    = (m_owner == 1) && (m_occ < DEPTH);
    e_r1    = (m_owner == 2) && (m_occ < DEPTH);
    e_acc0  = e_r0 && a0;
    e_acc1  = e_r1 && a1;
    e_out   = dr && (m_occ > 0);
    e_wdata = e_acc0 ? d0 : (e_acc1 ? d1 : '0);
    check("grant", 64'(grant), 64'(m_owner == 1 ? 1 : (m_owner == 2 ? 2 : 0)));
    check("req0_ready", 64'(r0), 64'(e_r0));
    check("req1_ready", 64'(r1), 64'(e_r1));
    check("buf_in_en", 64'(in_en), 64'(e_acc0 || e_acc1));
    check("buf_out_en", 64'(out_en), 64'(e_out));
    check("buf_wdata", 64'(wdata), 64'(e_wdata));
    check("dn_valid", 64'(dvalid), 64'(m_dvalid));
    check("occupancy", 64'(occ), 64'(m_occ));
`ifdef BUFFER_ARBITER_STATS_EN
    check("stat_cnt0", 64'(sc0), 64'(m_sc0));
    check("stat_cnt1", 64'(sc1), 64'(m_sc1));
`endif
    @(posedge clk);
`ifdef BUFFER_ARBITER_STATS_EN
    if (r || sclr) begin
      m_sc0 = 0; m_sc1 = 0;
    end else begin
      if (e_acc0 && m_sc0 < 64'hFFFF_FFFF) m_sc0++;
      if (e_acc1 && m_sc1 < 64'hFFFF_FFFF) m_sc1++;
    end
`endif
    if (r) begin
      m_owner = 0; m_last = 1; m_beats = 0; m_occ = 0; m_dvalid = 0;
    end else begin
      m_occ    = m_occ + int'(e_acc0 || e_acc1) - int'(e_out);
      m_dvalid = e_out;
      if (m_owner == 0) begin
        if (a0 && a1) m_owner = (1 - m_last) + 1;
        else if (a0)  m_owner = 1;
        else if (a1)  m_owner = 2;
      end else begin
        x     = m_owner - 1;
        other = 1 - x;
        vx    = (x == 0) ? a0 : a1;
        vo    = (x == 0) ? a1 : a0;
        if (e_acc0 || e_acc1) m_beats++;
        if (m_beats == BURST || !vx) begin
          m_last  = x;
          m_beats = 0;
          if (vo)       m_owner = other + 1;
          else if (!vx) m_owner = 0;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; dn = 1'b0; d0 = '0; d1 = '0;
    m_owner = 0; m_last = 1; m_beats = 0; m_occ = 0; m_dvalid = 0;
`ifdef BUFFER_ARBITER_STATS_EN
    m_sc0 = 0; m_sc1 = 0;
`endif
    @(posedge clk);

    // Reset state, then both ports valid: alternating 4-beat bursts.
    step(1, 0, 0, 0);
    step(1, 1, 1, 1);
    for (int i = 0; i < 20; i++) step(0, 1, 1, 1);

    // Single requester on port 1 for six words, then drain.
    step(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

    // Full stall: no reads, port 0 streams past capacity.
    step(1, 0, 0, 0);
    for (int i = 0; i < 11; i++) step(0, 1, 0, 0);
    check("full_occupancy", 64'(occ), 64'(DEPTH));
    check("full_ready", 64'(r0), 64'd0);
    step(0, 1, 0, 1);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);

    // Simultaneous read and write at occupancy 3.
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 1);

    // Reset in the middle of a burst, then port 0 wins the tie again.
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    step(1, 1, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
`ifdef BUFFER_ARBITER_STATS_EN
      sclr = ($urandom_range(0, 49) == 0);
`endif
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
